// File: rtl/dmac_apb_if.sv
// APB slave front end for the DMA controller configuration block: decodes APB
// transfers into one-hot write/read strobes for four config slots plus a version ID.
module dmac_apb_if #(
    parameter logic [11:0] CFG_BASE = 12'h100,
    parameter logic [31:0] VERSION  = 32'h0001_0101
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         psel,
    input  logic         penable,
    input  logic [11:0]  paddr,
    input  logic         pwrite,
    input  logic [31:0]  pwdata,
    output logic [31:0]  prdata,
    output logic         pready,
    output logic         pslverr,
    output logic [3:0]   wren_o,
    output logic [3:0]   rden_o,
    output logic [31:0]  wdata_o,
    input  logic [127:0] rdata_i
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        RDATA = 3'd3,
        VER   = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t      state;
    logic [1:0]  req_idx;
    logic [31:0] req_wdata;

    logic setup;
    logic slot_hit;
    logic ver_hit;

    assign setup    = psel && !penable;
    assign slot_hit = (paddr[11:4] == CFG_BASE[11:4]) && (paddr[1:0] == 2'b00);
    assign ver_hit  = (paddr == 12'h000);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_idx   <= 2'd0;
            req_wdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (setup) begin
                        req_idx   <= paddr[3:2];
                        req_wdata <= pwdata;
                        if (slot_hit)
                            state <= pwrite ? WR : RD;
                        else if (ver_hit && !pwrite)
                            state <= VER;
                        else
                            state <= ERR;
                    end
                end
                // A dropped psel abandons the read before the data phase.
                RD:      state <= psel ? RDATA : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are a pure decode of the state register and the latched request.
    always_comb begin
        prdata  = 32'd0;
        pready  = 1'b0;
        pslverr = 1'b0;
        wren_o  = 4'd0;
        rden_o  = 4'd0;
        wdata_o = 32'd0;
        case (state)
            WR: begin
                wren_o  = 4'b0001 << req_idx;
                wdata_o = req_wdata;
                pready  = 1'b1;
            end
            RD: begin
                rden_o = 4'b0001 << req_idx;
            end
            RDATA: begin
                // Only the strobed slot drives non-zero data, so OR acts as the mux.
                prdata = rdata_i[31:0] | rdata_i[63:32] | rdata_i[95:64] | rdata_i[127:96];
                pready = 1'b1;
            end
            VER: begin
                prdata = VERSION;
                pready = 1'b1;
            end
            ERR: begin
                pready  = 1'b1;
                pslverr = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmac_apb_if.sv
// Self-checking bench for dmac_apb_if: table vectors, hand-written corner
// sequences and randomized transfers against an address-map reference model.
module tb_dmac_apb_if;

    localparam logic [11:0] CFG_BASE = 12'h100;
    localparam logic [31:0] VERSION  = 32'h0001_0101;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         psel;
    logic         penable;
    logic [11:0]  paddr;
    logic         pwrite;
    logic [31:0]  pwdata;
    logic [31:0]  prdata;
    logic         pready;
    logic         pslverr;
    logic [3:0]   wren_o;
    logic [3:0]   rden_o;
    logic [31:0]  wdata_o;
    logic [127:0] rdata_i;

    int n_cmp = 0;
    int n_bad = 0;

    dmac_apb_if #(.CFG_BASE(CFG_BASE), .VERSION(VERSION)) dut (
        .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .paddr(paddr),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .wren_o(wren_o), .rden_o(rden_o), .wdata_o(wdata_o),
        .rdata_i(rdata_i)
    );

    always #5 clk = ~clk;

    // Config slot storage: captures writes, drives its value the cycle after rden.
    logic [31:0] slot_mem [4];
    logic [3:0]  rd_q;
    always @(posedge clk) begin
        if (!rst_n) begin
            rd_q <= 4'd0;
            for (int i = 0; i < 4; i++) slot_mem[i] <= 32'd0;
        end else begin
            rd_q <= rden_o;
            for (int i = 0; i < 4; i++) if (wren_o[i]) slot_mem[i] <= wdata_o;
        end
    end
    always_comb begin
        rdata_i = '0;
        for (int i = 0; i < 4; i++) if (rd_q[i]) rdata_i[32*i +: 32] = slot_mem[i];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) chk("strobe_onehot", 32'($countones(wren_o | rden_o) <= 1), 32'd1);
    end

    // Reference model: slot contents and the address map, from plain arithmetic.
    logic [31:0] ref_mem [4];

    function automatic int ref_decode(input bit wr, input logic [11:0] a);
        int off;
        off = int'(a) - int'(CFG_BASE);
        if (a == 12'h000) return wr ? -1 : -2;
        if (off >= 0 && off < 16 && (off % 4) == 0) return off / 4;
        return -1;
    endfunction

    task automatic ref_apply(input bit wr, input logic [11:0] a, input logic [31:0] d);
        int k;
        k = ref_decode(wr, a);
        if (wr && k >= 0) ref_mem[k] = d;
    endtask

    task automatic check_quiet(input string name);
        chk({name, "_pready"}, 32'(pready), 32'd0);
        chk({name, "_pslverr"}, 32'(pslverr), 32'd0);
        chk({name, "_strobes"}, 32'({wren_o, rden_o}), 32'd0);
        chk({name, "_prdata"}, prdata, 32'd0);
        chk({name, "_wdata"}, wdata_o, 32'd0);
    endtask

    // Called just after a rising edge; returns just after the edge that ends the
    // transfer, so the caller may drive the next setup phase back-to-back.
    task automatic xfer(input bit wr, input logic [11:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output bit err, output int cyc,
                        output logic [3:0] strb, output logic [31:0] wd, output bit tmo);
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = d;
        rd = '0; err = 1'b0; strb = '0; wd = '0; tmo = 1'b1; cyc = 1;
        @(negedge clk);
        strb |= wren_o | rden_o;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cyc++;
            strb |= wren_o | rden_o;
            if (wren_o != 4'd0) wd = wdata_o;
            if (pready) begin
                rd = prdata; err = pslverr; tmo = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        if (tmo) begin psel = 1'b0; penable = 1'b0; end
    endtask

    task automatic idle(input int n);
        psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    // Transfer checked against the reference model.
    task automatic model_xfer(input string name, input bit wr, input logic [11:0] a, input logic [31:0] d);
        logic [31:0] rd, wd;
        logic [3:0]  strb;
        bit          err, tmo;
        int          cyc, k;
        k = ref_decode(wr, a);
        xfer(wr, a, d, rd, err, cyc, strb, wd, tmo);
        chk({name, "_timeout"}, 32'(tmo), 32'd0);
        chk({name, "_pslverr"}, 32'(err), 32'(k == -1));
        chk({name, "_strobe"}, 32'(strb), (k >= 0) ? 32'(4'b0001 << k) : 32'd0);
        chk({name, "_cycles"}, 32'(cyc), (k >= 0 && !wr) ? 32'd3 : 32'd2);
        if (k == -2)            chk({name, "_prdata"}, rd, VERSION);
        else if (k >= 0 && !wr) chk({name, "_prdata"}, rd, ref_mem[k]);
        else                    chk({name, "_prdata"}, rd, 32'd0);
        if (k >= 0 && wr)       chk({name, "_wdata"}, wd, d);
        ref_apply(wr, a, d);
    endtask

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_err;
        logic [3:0]  exp_strb;
        int          exp_cyc;
    } vec_t;

    vec_t vt [13];

    initial begin
        logic [31:0] rd, wd;
        logic [3:0]  strb;
        bit          err, tmo, wr;
        int          cyc;
        logic [11:0] a;
        logic [31:0] d;

        vt[0]  = '{1'b1, 12'h104, 32'hDEAD_BEEF, 32'h0,         1'b0, 4'b0010, 2};
        vt[1]  = '{1'b0, 12'h104, 32'h0,         32'hDEAD_BEEF, 1'b0, 4'b0010, 3};
        vt[2]  = '{1'b1, 12'h10C, 32'h1234_5678, 32'h0,         1'b0, 4'b1000, 2};
        vt[3]  = '{1'b0, 12'h10C, 32'h0,         32'h1234_5678, 1'b0, 4'b1000, 3};
        vt[4]  = '{1'b0, 12'h000, 32'h0,         32'h0001_0101, 1'b0, 4'b0000, 2};
        vt[5]  = '{1'b1, 12'h000, 32'hFFFF_FFFF, 32'h0,         1'b1, 4'b0000, 2};
        vt[6]  = '{1'b0, 12'h200, 32'h0,         32'h0,         1'b1, 4'b0000, 2};
        vt[7]  = '{1'b1, 12'h102, 32'h5555_AAAA, 32'h0,         1'b1, 4'b0000, 2};
        vt[8]  = '{1'b0, 12'h100, 32'h0,         32'h0,         1'b0, 4'b0001, 3};
        vt[9]  = '{1'b1, 12'h100, 32'hA5A5_0001, 32'h0,         1'b0, 4'b0001, 2};
        vt[10] = '{1'b0, 12'h100, 32'h0,         32'hA5A5_0001, 1'b0, 4'b0001, 3};
        vt[11] = '{1'b0, 12'h1FC, 32'h0,         32'h0,         1'b1, 4'b0000, 2};
        vt[12] = '{1'b0, 12'h110, 32'h0,         32'h0,         1'b1, 4'b0000, 2};

        for (int i = 0; i < 4; i++) ref_mem[i] = 32'd0;
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0; pwdata = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("post_reset");
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            xfer(vt[i].wr, vt[i].addr, vt[i].wdata, rd, err, cyc, strb, wd, tmo);
            chk($sformatf("vec%0d_timeout", i), 32'(tmo), 32'd0);
            chk($sformatf("vec%0d_prdata", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_pslverr", i), 32'(err), 32'(vt[i].exp_err));
            chk($sformatf("vec%0d_strobe", i), 32'(strb), 32'(vt[i].exp_strb));
            chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vt[i].exp_cyc));
            if (vt[i].wr && !vt[i].exp_err) chk($sformatf("vec%0d_wdata", i), wd, vt[i].wdata);
            ref_apply(vt[i].wr, vt[i].addr, vt[i].wdata);
            if (i % 2 == 0) idle(1);
        end

        // After a write completes, the following cycle carries no strobes.
        xfer(1'b1, 12'h104, 32'hDEAD_BEEF, rd, err, cyc, strb, wd, tmo);
        ref_apply(1'b1, 12'h104, 32'hDEAD_BEEF);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        check_quiet("after_write");
        @(posedge clk); #1;

        // penable without a setup phase is ignored.
        psel = 1'b1; penable = 1'b1; paddr = 12'h108; pwrite = 1'b1; pwdata = 32'hBAD0_BAD0;
        repeat (2) begin
            @(negedge clk);
            check_quiet("no_setup");
            @(posedge clk); #1;
        end
        idle(1);

        // Abort: drop psel while the read strobe is out.
        psel = 1'b1; penable = 1'b0; paddr = 12'h100; pwrite = 1'b0;
        @(posedge clk); #1;
        psel = 1'b0;
        @(negedge clk);
        chk("abort_rden", 32'(rden_o), 32'b0001);
        chk("abort_rd_pready", 32'(pready), 32'd0);
        @(posedge clk); #1;
        repeat (2) begin
            @(negedge clk);
            check_quiet("abort_after");
            @(posedge clk); #1;
        end
        model_xfer("b2b_wr108", 1'b1, 12'h108, 32'hC0DE_0108);
        model_xfer("b2b_rd108", 1'b0, 12'h108, 32'h0);
        chk("b2b_rd108_direct", ref_mem[2], 32'hC0DE_0108);
        idle(1);

        // Reset asserted while in RD.
        psel = 1'b1; penable = 1'b0; paddr = 12'h10C; pwrite = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[i] = 32'd0;
        repeat (2) begin
            @(negedge clk);
            check_quiet("rst_in_rd");
            @(posedge clk); #1;
        end
        model_xfer("post_rst_rd", 1'b0, 12'h10C, 32'h0);

        for (int n = 0; n < 150; n++) begin
            wr = 1'($urandom_range(0, 1));
            d  = $urandom;
            case ($urandom_range(0, 4))
                0, 4:    a = CFG_BASE + 12'(4 * $urandom_range(0, 3));
                1:       a = 12'h000;
                2:       a = 12'($urandom);
                default: a = CFG_BASE + 12'($urandom_range(0, 15));
            endcase
            model_xfer($sformatf("rnd%0d", n), wr, a, d);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmac_apb_if.md
DMAC_APB_IF -- requirements
Module: dmac_apb_if

Interface
REQ-001 Parameter CFG_BASE, default 12'h100: byte offset of configuration slot 0; slots 0..3 at CFG_BASE+0x0/0x4/0x8/0xC.
REQ-002 Parameter VERSION, default 32'h0001_0101: read-only ID returned at offset 12'h000.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 psel  input  1  APB select.
REQ-006 penable  input  1  APB access-phase flag.
REQ-007 paddr  input  12  APB byte address.
REQ-008 pwrite  input  1  1 = write, 0 = read.
REQ-009 pwdata  input  32  APB write data.
REQ-010 prdata  output  32  APB read data, valid only when pready=1 on a read.
REQ-011 pready  output  1  transfer complete.
REQ-012 pslverr  output  1  error response, valid only when pready=1.
REQ-013 wren_o  output  4  one-hot write strobe per config slot.
REQ-014 rden_o  output  4  one-hot read strobe per config slot.
REQ-015 wdata_o  output  32  write data to slots.
REQ-016 rdata_i  input  128  slot read data, slot n on bits [32n+31:32n]; slot drives its registered value the cycle after its rden, 0 otherwise.

Function
REQ-017 FSM states IDLE, WR, RD, RDATA, VER, ERR; all outputs are decoded from the state register and the latched request.
REQ-018 IDLE: on psel=1 & penable=0, latch paddr, pwrite, pwdata and go to WR (mapped write), RD (mapped slot read), VER (read of 12'h000) or ERR (anything else); otherwise stay in IDLE.
REQ-019 Mapped slot: paddr[11:4]==CFG_BASE[11:4] and paddr[1:0]==2'b00; index = paddr[3:2].
REQ-020 ERR covers: unmapped offset, paddr[1:0]!=0, and a write to 12'h000.
REQ-021 WR: wren_o[index]=1 and wdata_o=latched pwdata for exactly this cycle; pready=1, pslverr=0; next state IDLE (zero-wait write, 2-cycle transfer).
REQ-022 RD: rden_o[index]=1 for exactly this cycle; pready=0; next state RDATA.
REQ-023 RDATA: prdata = bitwise OR of the four rdata_i words, pready=1, pslverr=0; next state IDLE (3-cycle read transfer).
REQ-024 VER: prdata=VERSION, pready=1, pslverr=0; next state IDLE.
REQ-025 ERR: pready=1, pslverr=1, prdata=0, no wren_o/rden_o; next state IDLE.
REQ-026 Outside WR, wren_o=0 and wdata_o=0; outside RD, rden_o=0; outside RDATA/VER, prdata=0; outside WR/RDATA/VER/ERR, pready=0 and pslverr=0.
REQ-027 Abort: psel=0 in any non-IDLE state forces next state IDLE; no further strobes for that transfer, and a strobe already issued in the current cycle is not repeated.
REQ-028 penable=1 while in IDLE (no setup phase seen) is ignored; the FSM stays in IDLE.
REQ-029 Back-to-back: a new setup phase in the cycle after pready=1 is accepted from IDLE with no extra idle cycle.
REQ-030 At most one bit of wren_o|rden_o is set in any cycle.

Reset
REQ-031 rst_n=0 at a rising edge forces state IDLE and clears the latched request; during and after reset prdata=0, pready=0, pslverr=0, wren_o=0, rden_o=0, wdata_o=0.
REQ-032 Reset mid-transfer discards the transfer with no strobe issued after the reset edge.

Verification
REQ-033 Write 0x104 data 32'hDEAD_BEEF -> in the access cycle wren_o=4'b0010, wdata_o=32'hDEAD_BEEF, pready=1, pslverr=0; the next cycle, all strobes are 0.
REQ-034 Read 0x10C with slot 3 returning 32'h1234_5678 the cycle after rden -> rden_o=4'b1000 in cycle 2 with pready=0; cycle 3 prdata=32'h1234_5678, pready=1.
REQ-035 Read 0x000 -> prdata=32'h0001_0101, pready=1 in the access cycle; write 0x000 -> pslverr=1, no strobes.
REQ-036 Access 0x200, then 0x102 -> each gives pready=1, pslverr=1, prdata=0, wren_o=rden_o=0.
REQ-037 Drop psel during RD of 0x100 -> next cycle IDLE, pready never asserted; then a back-to-back write to 0x108 then a read of 0x108 returns the written value.
REQ-038 Assert rst_n=0 during RD -> the next cycle all outputs are 0 and the state is IDLE.
